// File: rtl/inst_sram_loader_if.sv
// Byte-stream input and instruction-SRAM write port of the program loader.
// The loader takes the slave view; the byte source / SRAM side takes the master view.
interface inst_sram_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        inst_sram_wen;
  logic [63:0] inst_sram_waddr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_en_toif;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, inst_sram_wen, inst_sram_waddr, inst_sram_wdata, inst_sram_en_toif
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, inst_sram_wen, inst_sram_waddr, inst_sram_wdata, inst_sram_en_toif
  );
endinterface

// File: rtl/inst_sram_loader.sv
// Program loader ahead of mycpu_top: packs a little-endian byte stream into 32-bit words,
// writes them to instruction SRAM with the CPU held in reset, then releases the CPU.
module inst_sram_loader #(
  parameter int unsigned BASE_ADDR   = 1,
  parameter int unsigned MAX_WORDS   = 256,
  parameter int unsigned RELEASE_DLY = 2,
  parameter int unsigned CNT_W       = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  inst_sram_loader_if.slave bus,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              overflow,
  output logic              partial,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned DlyW = $clog2(RELEASE_DLY + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StFlush, StRelease, StRun, StError} state_e;

  state_e           state_q;
  logic [1:0]       byte_idx_q;
  logic [23:0]      acc_q;        // lower three bytes of the word being assembled
  logic [DlyW-1:0]  dly_q;
  logic             in_ready_q;
  logic             wen_q;
  logic             en_toif_q;
  logic [63:0]      waddr_q;
  logic [31:0]      wdata_q;
  logic             cpu_reset_q;
  logic             load_done_q;
  logic             overflow_q;
  logic             partial_q;
  logic [CNT_W-1:0] word_count_q;

  logic        accept;
  logic        word_done;
  logic        at_limit;
  logic [31:0] word;

  assign accept    = bus.in_valid && in_ready_q;
  assign word_done = accept && (bus.in_last || (byte_idx_q == 2'd3));
  assign at_limit  = (word_count_q == CNT_W'(MAX_WORDS));

  // Word as it stands once the current byte lands; unfilled upper bytes read as zero.
  always_comb begin
    unique case (byte_idx_q)
      2'd0:    word = {24'd0, bus.in_data};
      2'd1:    word = {16'd0, bus.in_data, acc_q[7:0]};
      2'd2:    word = {8'd0, bus.in_data, acc_q[15:0]};
      default: word = {bus.in_data, acc_q};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      byte_idx_q   <= 2'd0;
      acc_q        <= 24'd0;
      dly_q        <= '0;
      in_ready_q   <= 1'b0;
      wen_q        <= 1'b0;
      en_toif_q    <= 1'b0;
      waddr_q      <= 64'd0;
      wdata_q      <= 32'd0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      partial_q    <= 1'b0;
      word_count_q <= '0;
    end else begin
      wen_q <= 1'b0;
      unique case (state_q)
        StIdle, StRun, StError: begin
          if (start) begin
            state_q      <= StLoad;
            in_ready_q   <= 1'b1;
            cpu_reset_q  <= 1'b1;
            en_toif_q    <= 1'b0;
            load_done_q  <= 1'b0;
            byte_idx_q   <= 2'd0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            partial_q    <= 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            case (byte_idx_q)
              2'd0:    acc_q[7:0]   <= bus.in_data;
              2'd1:    acc_q[15:8]  <= bus.in_data;
              2'd2:    acc_q[23:16] <= bus.in_data;
              default: ;
            endcase
            byte_idx_q <= bus.in_last ? 2'd0 : byte_idx_q + 2'd1;
            // Past the limit, completed words are dropped but the stream keeps draining.
            if (word_done && at_limit) begin
              overflow_q <= 1'b1;
            end
            if (word_done && !at_limit) begin
              wen_q        <= 1'b1;
              waddr_q      <= 64'(BASE_ADDR) + 64'(word_count_q);
              wdata_q      <= word;
              word_count_q <= word_count_q + CNT_W'(1);
            end
            if (bus.in_last) begin
              in_ready_q <= 1'b0;
              if (byte_idx_q != 2'd3) begin
                partial_q <= 1'b1;
              end
              state_q <= at_limit ? StError : StFlush;
            end
          end
        end
        StFlush: begin
          state_q <= StRelease;
          dly_q   <= DlyW'(RELEASE_DLY);
        end
        StRelease: begin
          dly_q <= dly_q - DlyW'(1);
          if (dly_q == DlyW'(1)) begin
            state_q     <= StRun;
            cpu_reset_q <= 1'b0;
            en_toif_q   <= 1'b1;
            load_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.inst_sram_wen     = wen_q;
  assign bus.inst_sram_waddr   = waddr_q;
  assign bus.inst_sram_wdata   = wdata_q;
  assign bus.inst_sram_en_toif = en_toif_q;
  assign cpu_reset             = cpu_reset_q;
  assign load_done             = load_done_q;
  assign overflow              = overflow_q;
  assign partial               = partial_q;
  assign word_count            = word_count_q;

endmodule

// File: tb/tb_inst_sram_loader.sv
// Randomised bench for inst_sram_loader: a byte-level image model predicts every SRAM write,
// flag and release time; two DUTs cover the default word limit and a limit of 2.
module tb_inst_sram_loader;

  localparam int unsigned Base = 1;
  localparam int unsigned Dly  = 2;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       sel = 1'b0;   // 0: default limit DUT, 1: two-word limit DUT

  inst_sram_loader_if bus_a ();
  inst_sram_loader_if bus_b ();

  assign bus_a.in_valid = in_valid && !sel;
  assign bus_a.in_data  = in_data;
  assign bus_a.in_last  = in_last;
  assign bus_b.in_valid = in_valid && sel;
  assign bus_b.in_data  = in_data;
  assign bus_b.in_last  = in_last;

  logic       cpu_reset_a, load_done_a, overflow_a, partial_a;
  logic       cpu_reset_b, load_done_b, overflow_b, partial_b;
  logic [8:0] word_count_a, word_count_b;

  inst_sram_loader #(
    .BASE_ADDR   (1),
    .MAX_WORDS   (256),
    .RELEASE_DLY (2),
    .CNT_W       (9)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start && !sel),
    .bus        (bus_a),
    .cpu_reset  (cpu_reset_a),
    .load_done  (load_done_a),
    .overflow   (overflow_a),
    .partial    (partial_a),
    .word_count (word_count_a)
  );

  inst_sram_loader #(
    .BASE_ADDR   (1),
    .MAX_WORDS   (2),
    .RELEASE_DLY (2),
    .CNT_W       (9)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start && sel),
    .bus        (bus_b),
    .cpu_reset  (cpu_reset_b),
    .load_done  (load_done_b),
    .overflow   (overflow_b),
    .partial    (partial_b),
    .word_count (word_count_b)
  );

  logic        o_ready, o_wen, o_en, o_cpu_reset, o_done, o_ovf, o_part;
  logic [63:0] o_addr;
  logic [31:0] o_data;
  logic [8:0]  o_cnt;

  always_comb begin
    if (sel) begin
      o_ready = bus_b.in_ready;         o_wen  = bus_b.inst_sram_wen;
      o_addr  = bus_b.inst_sram_waddr;  o_data = bus_b.inst_sram_wdata;
      o_en    = bus_b.inst_sram_en_toif;
      o_cpu_reset = cpu_reset_b; o_done = load_done_b; o_ovf = overflow_b;
      o_part  = partial_b;              o_cnt  = word_count_b;
    end else begin
      o_ready = bus_a.in_ready;         o_wen  = bus_a.inst_sram_wen;
      o_addr  = bus_a.inst_sram_waddr;  o_data = bus_a.inst_sram_wdata;
      o_en    = bus_a.inst_sram_en_toif;
      o_cpu_reset = cpu_reset_a; o_done = load_done_a; o_ovf = overflow_a;
      o_part  = partial_a;              o_cnt  = word_count_a;
    end
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [7:0]  img_q[$];
  wr_t         exp_q[$];
  bit          exp_loading, exp_ovf, exp_part;
  int          run_at, exp_cnt;
  logic [63:0] last_addr;
  logic [31:0] last_data;
  int          vectors, miscompares;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int j);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (4 * j + k < img_q.size()) w[8*k +: 8] = img_q[4*j+k];
    end
    return w;
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) img_q.push_back(w[8*k +: 8]);
  endtask

  task automatic compare_loop();
    wr_t w;
    bit  exp_en;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst wen", o_wen, 0);           chk("rst waddr", o_addr, 0);
        chk("rst wdata", o_data, 0);        chk("rst en_toif", o_en, 0);
        chk("rst cpu_reset", o_cpu_reset, 1); chk("rst in_ready", o_ready, 0);
        chk("rst load_done", o_done, 0);    chk("rst overflow", o_ovf, 0);
        chk("rst partial", o_part, 0);      chk("rst word_count", o_cnt, 0);
      end else begin
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
          w = exp_q.pop_front();
          chk("wen pulse", o_wen, 1);
          last_addr = w.addr;
          last_data = w.data;
          exp_cnt++;
        end else begin
          chk("wen quiet", o_wen, 0);
        end
        exp_en = (run_at >= 0) && (cyc >= run_at);
        chk("waddr", o_addr, last_addr);
        chk("wdata", o_data, last_data);
        chk("word_count", o_cnt, 64'(exp_cnt));
        chk("in_ready", o_ready, exp_loading);
        chk("en_toif", o_en, exp_en);
        chk("cpu_reset", o_cpu_reset, !exp_en);
        chk("load_done", o_done, exp_en);
        chk("overflow", o_ovf, exp_ovf);
        chk("partial", o_part, exp_part);
      end
    end
  endtask

  task automatic apply_reset(input bit new_sel);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    exp_q.delete();
    exp_loading = 0; exp_ovf = 0; exp_part = 0; exp_cnt = 0; run_at = -1;
    last_addr = 64'd0; last_data = 32'd0;
    sel = new_sel;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_loading = 1; exp_ovf = 0; exp_part = 0; exp_cnt = 0; run_at = -1;
  endtask

  task automatic settle();
    repeat (Dly + 5) @(posedge clk);
    #1;
  endtask

  // Send up to 'limit' bytes of img_q; predicts each write from the byte index alone.
  task automatic send_image(input int limit, input int gap_max, input bit stray);
    int n, maxw, waited, hs_cyc, gap;
    bit acc, ovf_now;
    wr_t w;
    n = img_q.size();
    maxw = sel ? 2 : 256;
    for (int i = 0; i < limit && i < n; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        in_data = 8'($urandom);
        in_last = 1'($urandom);
        start   = stray && (g == 0) && (i == n / 2);
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      in_valid = 1'b1; in_data = img_q[i]; in_last = (i == n - 1);
      acc = 0; waited = 0; ovf_now = 0;
      while (!acc) begin
        @(negedge clk);
        acc = o_ready;
        hs_cyc = cyc;
        if (acc && (i % 4 == 3 || i == n - 1)) begin
          if (i / 4 < maxw) begin
            w.cyc = hs_cyc + 1;
            w.addr = 64'(Base) + 64'(i / 4);
            w.data = word_of(i / 4);
            exp_q.push_back(w);
          end else begin
            ovf_now = 1;
          end
        end
        @(posedge clk);
        #1;
        if (!acc) begin
          waited++;
          if (waited > 20) begin
            vectors++; miscompares++;
            $display("FAIL in_ready timeout on byte %0d: got 0, expected 1", i);
            in_valid = 1'b0; in_last = 1'b0;
            return;
          end
        end
      end
      if (ovf_now) exp_ovf = 1;
      if (i == n - 1) begin
        exp_loading = 0;
        if (i % 4 != 3) exp_part = 1;
        if (!exp_ovf) run_at = hs_cyc + 2 + Dly;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    run_at = -1;
    fork
      compare_loop();
    join_none
    apply_reset(1'b0);

    // Single word, CPU release timing
    img_q.delete(); push_word(32'h01400113);
    do_start();
    send_image(4, 0, 0);
    settle();
    chk("t1 waddr", o_addr, 64'd1);
    chk("t1 wdata", o_data, 32'h01400113);
    chk("t1 word_count", o_cnt, 9'd1);
    chk("t1 en_toif", o_en, 1);

    // Five words with gaps; start issued from RUN
    img_q.delete();
    push_word(32'h01400113);
    repeat (3) push_word(32'h00100A13);
    push_word(32'h00510193);
    do_start();
    chk("t5 cpu_reset", o_cpu_reset, 1);
    chk("t5 en_toif", o_en, 0);
    chk("t5 load_done", o_done, 0);
    send_image(20, 3, 1);
    settle();
    chk("t2 waddr", o_addr, 64'd5);
    chk("t2 wdata", o_data, 32'h00510193);
    chk("t2 word_count", o_cnt, 9'd5);
    chk("t2 partial", o_part, 0);

    // Six-byte image: padded second word
    img_q.delete(); push_word(32'h01400113);
    img_q.push_back(8'hAA); img_q.push_back(8'hBB);
    do_start();
    send_image(6, 1, 0);
    settle();
    chk("t3 waddr", o_addr, 64'd2);
    chk("t3 wdata", o_data, 32'h0000BBAA);
    chk("t3 partial", o_part, 1);
    chk("t3 cpu_reset", o_cpu_reset, 0);

    for (int r = 0; r < 8; r++) begin
      img_q.delete();
      for (int k = int'($urandom_range(24, 1)); k > 0; k--) img_q.push_back(8'($urandom));
      do_start();
      send_image(64, 3, 1);
      settle();
    end

    // Reset in the middle of a word
    img_q.delete(); push_word(32'hCAFEF00D);
    do_start();
    send_image(2, 1, 0);
    reset = 1'b1;
    #1;
    chk("t6 wen", o_wen, 0);
    chk("t6 wdata", o_data, 32'd0);
    chk("t6 cpu_reset", o_cpu_reset, 1);
    apply_reset(1'b0);
    img_q.delete(); push_word(32'h12345678);
    do_start();
    send_image(4, 0, 0);
    settle();
    chk("t6 wdata", o_data, 32'h12345678);
    chk("t6 waddr", o_addr, 64'd1);

    // Two-word limit: overflow then recovery from ERROR
    apply_reset(1'b1);
    img_q.delete();
    for (int k = 0; k < 12; k++) img_q.push_back(8'($urandom));
    do_start();
    send_image(12, 2, 0);
    settle();
    chk("t4 word_count", o_cnt, 9'd2);
    chk("t4 overflow", o_ovf, 1);
    chk("t4 cpu_reset", o_cpu_reset, 1);
    chk("t4 en_toif", o_en, 0);
    chk("t4 in_ready", o_ready, 0);
    img_q.delete(); push_word(32'hDEADBEEF);
    do_start();
    chk("t4 overflow cleared", o_ovf, 0);
    send_image(4, 0, 0);
    settle();
    chk("t4 waddr", o_addr, 64'd1);
    chk("t4 wdata", o_data, 32'hDEADBEEF);

    for (int r = 0; r < 8; r++) begin
      img_q.delete();
      for (int k = int'($urandom_range(14, 1)); k > 0; k--) img_q.push_back(8'($urandom));
      do_start();
      send_image(64, 2, 1);
      settle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
